tx_fsm: RTL and testbench
=========================

TX_FSM -- requirements
Module: tx_fsm

Interface
REQ-001 Params SHALL be: ADDR_WIDTH, default 9, memory address width; DATA_WIDTH, default 8, byte width; MAX_PACKET_CNT_VAL, default 20, counter saturation; C_SFD, default 32'h5555557F, preamble/SFD; C_PACKET_TYPE, default 16'h1234, type field; C_SIZE_MIN, default 8'h08, minimum payload length; C_IFG, default 12, inter-frame gap in cycles.
REQ-002 clk_in  in  1  single clock; reset is synchronous and active-high.
REQ-003 rst_in  in  1  synchronous active-high reset.
REQ-004 start_in  in  1  one-cycle frame request pulse.
REQ-005 base_addr_in  in  ADDR_WIDTH  first payload byte address.
REQ-006 size_in  in  8  payload length in bytes.
REQ-007 abort_in  in  1  abort the frame in progress.
REQ-008 rd_addr  out  ADDR_WIDTH  payload memory read address.
REQ-009 rd_en  out  1  payload memory read strobe.
REQ-010 rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en.
REQ-011 txd_out / txdv_out / txer_out  out  8/1/1  byte stream, data valid, error.
REQ-012 busy / done / rej  out  1/1/1  frame active; 1-cycle completion pulse; 1-cycle reject pulse.
REQ-013 stat_packet_tx_cnt / stat_packet_abt_cnt  out  16/16  sent and aborted frame counters.

Function
REQ-014 States SHALL be IDLE, SFD, TYPE, SIZE, PAYLOAD, FCS, ABORT, GAP.
REQ-015 In IDLE, start_in with size_in >= C_SIZE_MIN SHALL latch base_addr_in and size_in and enter SFD on the next edge, with busy high from that cycle.
REQ-016 In IDLE, start_in with size_in < C_SIZE_MIN SHALL pulse rej for 1 cycle and stay in IDLE with no txdv_out.
REQ-017 start_in outside IDLE SHALL be ignored.
REQ-018 The frame SHALL drive txdv_out high for exactly 8+N consecutive cycles: SFD MSB-first (55,55,55,7F), type MSB-first (12,34), size N, N payload bytes, then FCS.
REQ-019 rd_en SHALL assert during the SIZE cycle with rd_addr=base, and rd_addr SHALL increment by 1 each cycle for N reads, so that rd_data lands in txd_out with no gap.
REQ-020 FCS SHALL be the 8-bit modulo-256 sum of both type bytes and the size byte, so that the default FCS with N=8 is 8'h4E.
REQ-021 After FCS, GAP SHALL hold txdv_out low for C_IFG cycles, then enter IDLE, drop busy and pulse done.
REQ-022 rd_addr SHALL wrap modulo 2^ADDR_WIDTH.
REQ-023 abort_in in any state from SFD to FCS SHALL enter ABORT, which drives txdv_out=1 and txer_out=1 with txd_out=0 for 1 cycle and then enters GAP; done SHALL NOT pulse.
REQ-024 abort_in in IDLE or GAP SHALL be ignored; abort_in takes priority over a normal state advance on the same cycle.
REQ-025 stat_packet_tx_cnt SHALL increment on entering GAP from FCS, and stat_packet_abt_cnt SHALL increment on entering ABORT; both SHALL saturate at MAX_PACKET_CNT_VAL.
REQ-026 txd_out SHALL be 0 whenever txdv_out is low.

Reset
REQ-027 rst_in SHALL force IDLE and clear all outputs and counters to 0 on the same edge, including mid-frame, with no ABORT symbol emitted.

Configuration
REQ-028 With TX_FCS_PAYLOAD_EN defined, FCS SHALL additionally sum all N payload bytes mod 256; without it, FCS SHALL follow REQ-020, which is the mode compatible with rx_fsm.

Structure
REQ-029 Package pkt_pkg SHALL hold the default C_SFD, C_PACKET_TYPE, C_SIZE_MIN and byte-field offsets, which rx_fsm shares.
REQ-030 The tx_state_t typedef SHALL also live in pkt_pkg.
REQ-031 Sub-module tx_fcs_acc (clear, accumulate enable, byte in, 8-bit sum out) SHALL compute FCS.

Verification
REQ-032 start, base=0x010, N=8, memory=01..08 -> txd 55 55 55 7F 12 34 08 01..08 4E, 16 valid cycles, 12 gap cycles, done pulse, tx_cnt=1.
REQ-033 start with N=7 -> rej pulse, txdv_out stays 0, both counters unchanged.
REQ-034 abort_in on the 3rd payload byte -> one cycle txer=1/txd=00, then GAP, abt_cnt=1, no done.
REQ-035 21 good frames -> tx_cnt saturates at 20; base=0x1FE, N=8 -> rd_addr 1FE,1FF,000..005.
REQ-036 rst_in asserted mid-PAYLOAD -> next cycle all outputs 0 and state IDLE; with TX_FCS_PAYLOAD_EN defined and payload 01..08 -> FCS 8'h72.

Source files
------------

// File: rtl/pkt_pkg.sv
// pkt_pkg: frame constants, field offsets and TX state encoding shared by tx_fsm and rx_fsm.
package pkt_pkg;
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t S_IDLE    = 3'd0;
  localparam tx_state_t S_SFD     = 3'd1;
  localparam tx_state_t S_TYPE    = 3'd2;
  localparam tx_state_t S_SIZE    = 3'd3;
  localparam tx_state_t S_PAYLOAD = 3'd4;
  localparam tx_state_t S_FCS     = 3'd5;
  localparam tx_state_t S_ABORT   = 3'd6;
  localparam tx_state_t S_GAP     = 3'd7;
  localparam logic [31:0] C_SFD_DEF         = 32'h5555557F;
  localparam logic [15:0] C_PACKET_TYPE_DEF = 16'h1234;
  localparam logic [7:0]  C_SIZE_MIN_DEF    = 8'h08;
  localparam int OFS_SFD     = 0;
  localparam int OFS_TYPE    = 4;
  localparam int OFS_SIZE    = 6;
  localparam int OFS_PAYLOAD = 7;
endpackage

// File: rtl/tx_fcs_acc.sv
// tx_fcs_acc: modulo-256 byte accumulator for the frame check byte.
module tx_fcs_acc (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);
  always_ff @(posedge clk_in) begin
    if (rst_in || clr) sum <= '0;
    else if (en) sum <= sum + din;
  end
endmodule

// File: rtl/tx_fsm.sv
// tx_fsm: frame transmitter (SFD, type, size, payload, FCS, gap) with abort and stats.
// Define TX_FCS_PAYLOAD_EN to include payload bytes in the FCS sum.
module tx_fsm
  import pkt_pkg::*;
#(
  parameter int          ADDR_WIDTH         = 9,
  parameter int          DATA_WIDTH         = 8,
  parameter int          MAX_PACKET_CNT_VAL = 20,
  parameter logic [31:0] C_SFD              = C_SFD_DEF,
  parameter logic [15:0] C_PACKET_TYPE      = C_PACKET_TYPE_DEF,
  parameter logic [7:0]  C_SIZE_MIN         = C_SIZE_MIN_DEF,
  parameter int          C_IFG              = 12
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [7:0]            size_in,
  input  logic                  abort_in,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            txd_out,
  output logic                  txdv_out,
  output logic                  txer_out,
  output logic                  busy,
  output logic                  done,
  output logic                  rej,
  output logic [15:0]           stat_packet_tx_cnt,
  output logic [15:0]           stat_packet_abt_cnt
);
  localparam logic [15:0] CNT_MAX  = 16'(MAX_PACKET_CNT_VAL);
  localparam logic [7:0]  IFG_LAST = 8'(C_IFG - 1);
  tx_state_t state;
  logic [7:0] cnt, size_q, fcs_sum;
  logic aborted, pay_last, fcs_en;
  assign pay_last = cnt == size_q - 8'd1;
  assign busy     = state != S_IDLE;
  assign txdv_out = busy && state != S_GAP;
  assign txer_out = state == S_ABORT;
  // Reads run one cycle ahead so rd_data lines up with the PAYLOAD cycles.
  assign rd_en    = state == S_SIZE || (state == S_PAYLOAD && !pay_last);
`ifdef TX_FCS_PAYLOAD_EN
  assign fcs_en   = state == S_TYPE || state == S_SIZE || state == S_PAYLOAD;
`else
  assign fcs_en   = state == S_TYPE || state == S_SIZE;
`endif
  assign txd_out  = state == S_SFD     ? 8'(C_SFD >> {~cnt[1:0], 3'b000}) :
                    state == S_TYPE    ? (cnt[0] ? C_PACKET_TYPE[7:0] : C_PACKET_TYPE[15:8]) :
                    state == S_SIZE    ? size_q :
                    state == S_PAYLOAD ? 8'(rd_data) :
                    state == S_FCS     ? fcs_sum : 8'h00;
  tx_fcs_acc u_fcs (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (state == S_IDLE),
    .en     (fcs_en),
    .din    (txd_out),
    .sum    (fcs_sum)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      size_q              <= '0;
      rd_addr             <= '0;
      aborted             <= 1'b0;
      done                <= 1'b0;
      rej                 <= 1'b0;
      stat_packet_tx_cnt  <= '0;
      stat_packet_abt_cnt <= '0;
    end else begin
      done <= 1'b0;
      rej  <= 1'b0;
      if (rd_en) rd_addr <= rd_addr + 1'b1;
      if (abort_in && txdv_out && !txer_out) begin
        state   <= S_ABORT;
        cnt     <= '0;
        aborted <= 1'b1;
        if (stat_packet_abt_cnt != CNT_MAX) stat_packet_abt_cnt <= stat_packet_abt_cnt + 16'd1;
      end else begin
        case (state)
          S_IDLE: if (start_in) begin
            if (size_in >= C_SIZE_MIN) begin
              state   <= S_SFD;
              cnt     <= '0;
              rd_addr <= base_addr_in;
              size_q  <= size_in;
              aborted <= 1'b0;
            end else rej <= 1'b1;
          end
          S_SFD: begin
            state <= cnt == 8'd3 ? S_TYPE : S_SFD;
            cnt   <= cnt == 8'd3 ? 8'd0 : cnt + 8'd1;
          end
          S_TYPE: begin
            state <= cnt[0] ? S_SIZE : S_TYPE;
            cnt   <= cnt[0] ? 8'd0 : cnt + 8'd1;
          end
          S_SIZE: state <= S_PAYLOAD;
          S_PAYLOAD: begin
            state <= pay_last ? S_FCS : S_PAYLOAD;
            cnt   <= pay_last ? 8'd0 : cnt + 8'd1;
          end
          S_FCS: begin
            state <= S_GAP;
            cnt   <= '0;
            if (stat_packet_tx_cnt != CNT_MAX) stat_packet_tx_cnt <= stat_packet_tx_cnt + 16'd1;
          end
          S_ABORT: begin
            state <= S_GAP;
            cnt   <= '0;
          end
          default: begin
            state <= cnt == IFG_LAST ? S_IDLE : S_GAP;
            cnt   <= cnt == IFG_LAST ? 8'd0 : cnt + 8'd1;
            done  <= cnt == IFG_LAST && !aborted;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tx_fsm.sv
// tb_tx_fsm: directed self-checking bench for tx_fsm.
module tb_tx_fsm;
`ifdef TX_FCS_PAYLOAD_EN
  localparam logic [7:0] EXP_FCS = 8'h72;
`else
  localparam logic [7:0] EXP_FCS = 8'h4E;
`endif
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [8:0] base_addr = '0, rd_addr;
  logic [7:0] size = '0, rd_data = '0, txd;
  logic rd_en, txdv, txer, busy, done, rej;
  logic [15:0] tx_cnt, abt_cnt;
  logic [7:0] mem [512];
  logic [7:0] got [$];
  logic [8:0] addrs [$];
  int valid_n, gap_n, done_n, rej_n, err_n, bad_idle, busy_n;
  int tests = 0, fails = 0;

  tx_fsm dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .base_addr_in(base_addr), .size_in(size),
    .abort_in(abort), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .txd_out(txd),
    .txdv_out(txdv), .txer_out(txer), .busy(busy), .done(done), .rej(rej),
    .stat_packet_tx_cnt(tx_cnt), .stat_packet_abt_cnt(abt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Pulses start, records the frame until busy falls; abort fires on valid cycle abort_at.
  task automatic send(input logic [8:0] b, input logic [7:0] n, input int abort_at);
    got.delete(); addrs.delete();
    valid_n = 0; gap_n = 0; done_n = 0; rej_n = 0; err_n = 0; bad_idle = 0; busy_n = 0;
    @(negedge clk);
    start = 1; base_addr = b; size = n;
    for (int c = 0; ; c++) begin
      if (c == 400) begin
        tests++; fails++;
        $display("FAIL send_timeout: busy=%0b after %0d cycles, required busy=0", busy, c);
        break;
      end
      @(negedge clk);
      start = 0;
      if (txdv) begin got.push_back(txd); valid_n++; end
      else if (txd !== 8'h00) bad_idle++;
      if (busy && !txdv) gap_n++;
      if (txer) err_n++;
      if (rd_en) addrs.push_back(rd_addr);
      done_n += int'(done); rej_n += int'(rej); busy_n += int'(busy);
      abort = txdv && !txer && (valid_n - 1 == abort_at);
      if (!busy && (busy_n > 0 || c >= 4)) break;
    end
    abort = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({txdv, txer, txd, busy, done, rej, rd_en, rd_addr, tx_cnt, abt_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: txdv=%b txd=%h busy=%b rd_addr=%h tx=%0d abt=%0d, required all 0",
               txdv, txd, busy, rd_addr, tx_cnt, abt_cnt);
    end
    rst = 0;
  endtask

  task automatic test_frame;
    logic [7:0] exp_b [16] = '{8'h55, 8'h55, 8'h55, 8'h7F, 8'h12, 8'h34, 8'h08,
                               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, EXP_FCS};
    send(9'h010, 8'd8, -1);
    tests++; if (valid_n !== 16) begin fails++; $display("FAIL frame_valid: got %0d, required 16", valid_n); end
    for (int i = 0; i < 16 && i < valid_n; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++; $display("FAIL frame_byte[%0d]: got %h, required %h", i, got[i], exp_b[i]); end
    end
    tests++; if (gap_n !== 12) begin fails++; $display("FAIL frame_gap: got %0d, required 12", gap_n); end
    tests++; if (done_n !== 1) begin fails++; $display("FAIL frame_done: got %0d, required 1", done_n); end
    tests++; if (err_n !== 0) begin fails++; $display("FAIL frame_txer: got %0d, required 0", err_n); end
    tests++; if (bad_idle !== 0) begin fails++; $display("FAIL frame_idle_txd: got %0d, required 0", bad_idle); end
    tests++; if (tx_cnt !== 16'd1) begin fails++; $display("FAIL frame_tx_cnt: got %0d, required 1", tx_cnt); end
    tests++; if (addrs.size() !== 8) begin fails++; $display("FAIL frame_reads: got %0d, required 8", addrs.size()); end
    for (int k = 0; k < 8 && k < addrs.size(); k++) begin
      tests++;
      if (addrs[k] !== 9'(16 + k)) begin fails++; $display("FAIL frame_addr[%0d]: got %h, required %h", k, addrs[k], 9'(16 + k)); end
    end
  endtask

  task automatic test_reject;
    send(9'h010, 8'd7, -1);
    tests++; if (rej_n !== 1) begin fails++; $display("FAIL rej_pulse: got %0d, required 1", rej_n); end
    tests++; if (valid_n !== 0) begin fails++; $display("FAIL rej_txdv: got %0d, required 0", valid_n); end
    tests++; if (busy_n !== 0) begin fails++; $display("FAIL rej_busy: got %0d, required 0", busy_n); end
    tests++; if ({tx_cnt, abt_cnt} !== {16'd1, 16'd0}) begin
      fails++; $display("FAIL rej_counters: got tx=%0d abt=%0d, required tx=1 abt=0", tx_cnt, abt_cnt);
    end
  endtask

  task automatic test_abort;
    send(9'h010, 8'd8, 9);
    tests++; if (valid_n !== 11) begin fails++; $display("FAIL abort_valid: got %0d, required 11", valid_n); end
    tests++; if (valid_n == 11 && got[9] !== 8'h03) begin fails++; $display("FAIL abort_third_byte: got %h, required 03", got[9]); end
    tests++; if (valid_n == 11 && got[10] !== 8'h00) begin fails++; $display("FAIL abort_symbol: got %h, required 00", got[10]); end
    tests++; if (err_n !== 1) begin fails++; $display("FAIL abort_txer: got %0d, required 1", err_n); end
    tests++; if (gap_n !== 12) begin fails++; $display("FAIL abort_gap: got %0d, required 12", gap_n); end
    tests++; if (done_n !== 0) begin fails++; $display("FAIL abort_done: got %0d, required 0", done_n); end
    tests++; if ({tx_cnt, abt_cnt} !== {16'd1, 16'd1}) begin
      fails++; $display("FAIL abort_counters: got tx=%0d abt=%0d, required tx=1 abt=1", tx_cnt, abt_cnt);
    end
  endtask

  task automatic test_saturate_wrap;
    repeat (19) send(9'h010, 8'd8, -1);
    tests++; if (tx_cnt !== 16'd20) begin fails++; $display("FAIL sat_reach: got %0d, required 20", tx_cnt); end
    send(9'h010, 8'd8, -1);
    tests++; if (tx_cnt !== 16'd20) begin fails++; $display("FAIL sat_hold: got %0d, required 20", tx_cnt); end
    send(9'h1FE, 8'd8, -1);
    tests++; if (addrs.size() !== 8) begin fails++; $display("FAIL wrap_reads: got %0d, required 8", addrs.size()); end
    for (int k = 0; k < 8 && k < addrs.size() && k + 7 < valid_n; k++) begin
      logic [8:0] e;
      e = 9'h1FE + 9'(k);
      tests++;
      if (addrs[k] !== e) begin fails++; $display("FAIL wrap_addr[%0d]: got %h, required %h", k, addrs[k], e); end
      tests++;
      if (got[7 + k] !== 8'hA0 + 8'(k)) begin fails++; $display("FAIL wrap_byte[%0d]: got %h, required %h", k, got[7 + k], 8'hA0 + 8'(k)); end
    end
  endtask

  task automatic test_mid_reset;
    int seen = 0;
    @(negedge clk);
    start = 1; base_addr = 9'h010; size = 8'd8;
    for (int c = 0; c < 50 && seen < 10; c++) begin
      @(negedge clk);
      start = 0;
      seen += int'(txdv);
    end
    rst = 1;
    @(negedge clk);
    tests++;
    if ({txdv, txer, txd, busy, done, rej, rd_en, rd_addr, tx_cnt, abt_cnt} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: txdv=%b txer=%b txd=%h busy=%b rd_en=%b rd_addr=%h tx=%0d abt=%0d, required all 0",
               txdv, txer, txd, busy, rd_en, rd_addr, tx_cnt, abt_cnt);
    end
    rst = 0;
    send(9'h010, 8'd8, -1);
    tests++; if (valid_n !== 16 || tx_cnt !== 16'd1) begin
      fails++; $display("FAIL midrst_recover: got valid=%0d tx=%0d, required valid=16 tx=1", valid_n, tx_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    for (int k = 0; k < 8; k++) mem[16 + k] = 8'(k + 1);
    for (int k = 0; k < 8; k++) mem[9'(9'h1FE + 9'(k))] = 8'hA0 + 8'(k);
    test_reset;
    test_frame;
    test_reject;
    test_abort;
    test_saturate_wrap;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
